muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for the iterative multiply/divide unit. Decode emits alufunc MUL/DIV/REM plus alu_sign and alu_cut.
- Accepts one operation at a time and runs a 1-bit-per-cycle shift-add multiplier or restoring divider. Holds the pipeline stalled via in_ready=0 until the result pulse.
- Handles RISC-V divide-by-zero, signed overflow and W-form (32-bit, sign-extended) results.

Parameters:
- XLEN, 64, datapath width; W-forms operate on XLEN/2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low; state cleared on rising clk while reset==0
- in_valid  in  1  request from execute
- in_ready  out  1  high only in IDLE; accept = in_valid && in_ready && !flush
- op  in  2  00 MUL (low product), 01 DIV, 10 REM; 11 illegal, treated as MUL
- sign  in  1  signed DIV/REM (alu_sign); ignored for MUL
- cut  in  1  W-form (alu_cut)
- a  in  XLEN  rs1 / dividend
- b  in  XLEN  rs2 / divisor
- flush  in  1  abort current op
- out_valid  out  1  one-cycle result pulse
- result  out  XLEN  valid when out_valid; holds last value otherwise

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, iteration counter=0.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE→PREP on accept. Latch op, sign, cut, a, b.
- If cut=1, narrow the operands to the low XLEN/2 bits: sign-extended when sign=1, zero-extended otherwise. N=XLEN/2 when cut=1, else XLEN.
- PREP (1 cycle):
  - DIV/REM with b==0: skip to DONE. Quotient=all ones; remainder=dividend.
  - Signed DIV/REM with dividend=most-negative and b=-1: skip to DONE. Quotient=dividend; remainder=0.
  - Otherwise, signed: take absolute values, record neg_q=sa^sb and neg_r=sa. Load the counter with N, then go to RUN.
- RUN (exactly N cycles; counter decrements each cycle; leave on counter==1):
  - MUL: if multiplier LSB is set, acc += multiplicand. Multiplicand <<1, multiplier >>1. Keep only the low XLEN bits (low product is identical signed or unsigned).
  - DIV: shift {rem,quo} left by 1. If rem>=divisor, subtract the divisor and set the quo LSB.
- FIX (1 cycle): apply negation (quotient if neg_q, remainder if neg_r). Select quotient/remainder/product.
- Result formatting:
  - cut=1: take the low XLEN/2 bits and sign-extend to XLEN. This applies to MULW/DIVW/DIVUW/REMW/REMUW; unsigned W results are also sign-extended, per ISA.
  - Fast-path W results are formatted the same way.
- DONE (1 cycle): out_valid=1, result driven, then IDLE. in_ready=0 in DONE, so back-to-back ops need one IDLE cycle.
- Latency: accept at edge 0 → out_valid in cycle N+3. Fast path → out_valid in cycle 2.
- flush=1 in any state: next state IDLE, no out_valid, result unchanged. flush beats in_valid in the same cycle (no accept).
- reset==0 mid-operation: same as flush, plus result cleared to 0.
- in_valid while busy is ignored; upstream must hold its request.
- Operand inputs are sampled only on accept; later changes have no effect.

Optional Feature:
- MULDIV_EARLY_EXIT_EN defined: in RUN for MUL, leave for FIX as soon as the remaining multiplier is zero. Latency becomes (index of highest set multiplier bit + 1) + 3, minimum 3 cycles for multiplier 0 (RUN is bypassed). DIV timing is unchanged.
- Not defined: MUL always takes N cycles in RUN. Result values are identical either way.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD), cut=0 → result 0xFFFF_FFFF_FFFF_FFEB (-21). out_valid exactly 67 cycles after accept (feature off).
- DIV sign=1 a=-20, b=3 → result -6. REM same operands → -2. REMU a=20, b=3 → 2. in_ready=0 throughout.
- DIV b=0, a=5 → 0xFFFF_FFFF_FFFF_FFFF; REM b=0, a=5 → 5. Both at cycle 2. Signed DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000; REM → 0.
- DIVUW cut=1 a=0x1_FFFF_FFFF, b=1 → 0xFFFF_FFFF_FFFF_FFFF (sign-extended). MULW a=0x4000_0000, b=2 → 0xFFFF_FFFF_8000_0000, at cycle 35.
- Flush in RUN cycle 10 → no out_valid, in_ready=1 next cycle. New MUL 3×5 accepted that cycle → 15. Flush and in_valid together in IDLE → not accepted.
- reset=0 during RUN → next cycle state IDLE, result=0, out_valid=0. With MULDIV_EARLY_EXIT_EN, MUL a=9, b=1 → result 9 at cycle 4.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Execute-stage multiply/divide sequencer: 1-bit-per-cycle shift-add multiply, restoring divide.
// Define MULDIV_EARLY_EXIT_EN to end MUL as soon as the remaining multiplier is zero.
module muldiv_ctrl #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            sign,
    input  logic            cut,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned HALF = XLEN / 2;
    localparam int unsigned CW   = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic            is_mul_q, is_rem_q, sign_q, cut_q;
    logic [XLEN-1:0] a_q, b_q;
    // acc: product; md: multiplicand or dividend/quotient shifter; mr: multiplier or divisor
    logic [XLEN-1:0] acc_q, md_q, mr_q, rem_q;
    logic [CW-1:0]   cnt_q;
    logic            negq_q, negr_q;
    logic [XLEN-1:0] pend_q, result_q;

    logic            accept, divrem_in, sx_in;
    logic [XLEN-1:0] a_nar, b_nar;
    logic            sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, min_neg, fast_res;
    logic [CW-1:0]   n_bits;
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] rem_nx, quo_nx, acc_nx, q_fix, r_fix, sel_res;

    function automatic logic [XLEN-1:0] narrow(input logic [XLEN-1:0] v, input logic sx);
        narrow = {{HALF{sx & v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic w);
        fmt = w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    assign in_ready  = (state_q == StIdle);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == StDone) && !flush && reset;
    assign result    = out_valid ? pend_q : result_q;

    always_comb begin
        divrem_in = (op == 2'b01) || (op == 2'b10);
        sx_in     = sign && divrem_in;
        a_nar     = cut ? narrow(a, sx_in) : a;
        b_nar     = cut ? narrow(b, sx_in) : b;
    end

    always_comb begin
        sa       = sign_q && a_q[XLEN-1];
        sb       = sign_q && b_q[XLEN-1];
        abs_a    = sa ? -a_q : a_q;
        abs_b    = sb ? -b_q : b_q;
        min_neg  = cut_q ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}}
                         : {1'b1, {(XLEN - 1){1'b0}}};
        div_zero = !is_mul_q && (b_q == '0);
        div_ovf  = !is_mul_q && sign_q && (a_q == min_neg) && (b_q == '1);
        if (div_zero) begin
            fast_res = is_rem_q ? a_q : '1;
        end else begin
            fast_res = is_rem_q ? '0 : a_q;
        end
        n_bits   = cut_q ? CW'(HALF) : CW'(XLEN);

        rem_sh   = {rem_q, md_q[XLEN-1]};
        rem_ge   = (rem_sh >= {1'b0, mr_q});
        rem_nx   = rem_ge ? XLEN'(rem_sh - {1'b0, mr_q}) : rem_sh[XLEN-1:0];
        quo_nx   = {md_q[XLEN-2:0], rem_ge};
        acc_nx   = mr_q[0] ? acc_q + md_q : acc_q;

        q_fix    = negq_q ? -md_q : md_q;
        r_fix    = negr_q ? -rem_q : rem_q;
        sel_res  = is_mul_q ? acc_q : (is_rem_q ? r_fix : q_fix);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = StPrep;
            StPrep: begin
                if (div_zero || div_ovf) begin
                    state_d = StDone;
`ifdef MULDIV_EARLY_EXIT_EN
                end else if (is_mul_q && (b_q == '0)) begin
                    state_d = StFix;
`endif
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
`ifdef MULDIV_EARLY_EXIT_EN
                if ((cnt_q == CW'(1)) || (is_mul_q && (mr_q[XLEN-1:1] == '0))) begin
                    state_d = StFix;
                end
`else
                if (cnt_q == CW'(1)) state_d = StFix;
`endif
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            sign_q   <= 1'b0;
            cut_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            md_q     <= '0;
            mr_q     <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            pend_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        is_mul_q <= !divrem_in;
                        is_rem_q <= (op == 2'b10);
                        sign_q   <= sx_in;
                        cut_q    <= cut;
                        a_q      <= a_nar;
                        b_q      <= b_nar;
                    end
                end
                StPrep: begin
                    cnt_q  <= n_bits;
                    acc_q  <= '0;
                    rem_q  <= '0;
                    negq_q <= sa ^ sb;
                    negr_q <= sa;
                    if (is_mul_q) begin
                        md_q <= a_q;
                        mr_q <= b_q;
                    end else begin
                        // W-form dividend is pre-aligned so its MSB enters the remainder first
                        md_q <= cut_q ? (abs_a << HALF) : abs_a;
                        mr_q <= abs_b;
                    end
                    pend_q <= fmt(fast_res, cut_q);
                end
                StRun: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (is_mul_q) begin
                        acc_q <= acc_nx;
                        md_q  <= md_q << 1;
                        mr_q  <= mr_q >> 1;
                    end else begin
                        rem_q <= rem_nx;
                        md_q  <= quo_nx;
                    end
                end
                StFix: pend_q <= fmt(sel_res, cut_q);
                StDone: begin
                    if (!flush) result_q <= pend_q;
                end
                default: ;
            endcase
        end
    end

endmodule
